sonar_scan_ctrl: RTL and testbench

Sequences a bank of ultrasonic range sensors. Issues a trigger pulse to one sensor at a time, measures the echo pulse width in clock cycles, applies the near/far detection window, and advances round-robin to the next sensor after a holdoff. Sits between the sensor I/O pins and the motion logic: per-sensor `detected` flags feed obstacle avoidance, and the aggregate `run` output feeds the drive enable.

---
 rtl/sonar_pkg.sv | 22 ++
 rtl/echo_sync.sv | 21 ++
 rtl/sonar_scan_ctrl.sv | 135 +++++++++++++
 tb/tb_sonar_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default timing for the ultrasonic sensor scanner.
package sonar_pkg;
    localparam int MEAS_W          = 24;
    localparam int DEF_N_SENSORS   = 4;
    localparam int DEF_TRIG_CYC    = 1000;
    localparam int DEF_TIMEOUT_CYC = 2_500_000;
    localparam int DEF_HOLDOFF_CYC = 6_000_000;
    localparam int DEF_NEAR_CYC    = 17400;
    localparam int DEF_FAR_CYC     = 116000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } scan_state_t;

    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
        return (&v) ? v : v + MEAS_W'(1);
    endfunction
endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the asynchronous echo lines.
module echo_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/sonar_scan_ctrl.sv
// Round-robin ultrasonic scanner: trigger, echo width measurement, near/far
// window detection and holdoff between sensors.
module sonar_scan_ctrl
    import sonar_pkg::*;
#(
    parameter int N_SENSORS   = DEF_N_SENSORS,
    parameter int TRIG_CYC    = DEF_TRIG_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int HOLDOFF_CYC = DEF_HOLDOFF_CYC,
    parameter int NEAR_CYC    = DEF_NEAR_CYC,
    parameter int FAR_CYC     = DEF_FAR_CYC
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trig,
    output logic [N_SENSORS-1:0] detected,
    output logic                 run,
    output logic                 meas_valid,
    output logic [2:0]           meas_idx,
    output logic [MEAS_W-1:0]    meas_cycles,
    output logic                 meas_timeout
);
    localparam logic [MEAS_W-1:0] TRIG_LAST = MEAS_W'(TRIG_CYC - 1);
    localparam logic [MEAS_W-1:0] HOLD_LAST = MEAS_W'(HOLDOFF_CYC - 1);
    localparam logic [MEAS_W-1:0] TO_C      = MEAS_W'(TIMEOUT_CYC);
    localparam logic [MEAS_W-1:0] NEAR_C    = MEAS_W'(NEAR_CYC);
    localparam logic [MEAS_W-1:0] FAR_C     = MEAS_W'(FAR_CYC);

    scan_state_t          state;
    logic [MEAS_W-1:0]    cnt;
    logic [2:0]           idx, idx_next;
    logic [N_SENSORS-1:0] es, es_d, sel, sel_next, det_next;
    logic                 es_cur, es_rise, done, done_to, in_win;

    echo_sync #(.W(N_SENSORS)) u_sync (.clk(clk), .rst_n(rst_n), .d(echo), .q(es));

    assign idx_next = (idx == 3'(N_SENSORS - 1)) ? 3'd0 : idx + 3'd1;
    assign sel      = N_SENSORS'(1) << idx;
    assign sel_next = N_SENSORS'(1) << idx_next;
    assign es_cur   = |(es & sel);
    // es_d carries the level seen during TRIG, so an echo already high is not an edge
    assign es_rise  = |(es & ~es_d & sel);
    assign in_win   = (cnt > NEAR_C) && (cnt < FAR_C);

    always_comb begin
        done    = 1'b0;
        done_to = 1'b0;
        if (enable) begin
            case (state)
                ST_WAIT_RISE: if (!es_rise && cnt >= TO_C) begin
                    done    = 1'b1;
                    done_to = 1'b1;
                end
                ST_MEASURE: if (!es_cur) begin
                    done = 1'b1;
                end else if (cnt >= TO_C) begin
                    done    = 1'b1;
                    done_to = 1'b1;
                end
                default: ;
            endcase
        end
        det_next = detected;
        if (done)
            det_next = (detected & ~sel) | ((!done_to && in_win) ? sel : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            idx          <= '0;
            es_d         <= '0;
            trig         <= '0;
            detected     <= '0;
            run          <= 1'b0;
            meas_valid   <= 1'b0;
            meas_idx     <= '0;
            meas_cycles  <= '0;
            meas_timeout <= 1'b0;
        end else begin
            es_d       <= es;
            meas_valid <= 1'b0;
            detected   <= det_next;
            run        <= |det_next;
            if (done) begin
                meas_valid   <= 1'b1;
                meas_idx     <= idx;
                meas_cycles  <= cnt;
                meas_timeout <= done_to;
                state        <= ST_HOLDOFF;
                cnt          <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (enable) begin
                        state <= ST_TRIG;
                        cnt   <= '0;
                        trig  <= sel;
                    end
                    ST_TRIG, ST_WAIT_RISE, ST_MEASURE: begin
                        if (!enable) begin
                            state <= ST_IDLE;
                            trig  <= '0;
                            cnt   <= '0;
                        end else if (state == ST_TRIG && cnt == TRIG_LAST) begin
                            state <= ST_WAIT_RISE;
                            trig  <= '0;
                            cnt   <= '0;
                        end else if (state == ST_WAIT_RISE && es_rise) begin
                            state <= ST_MEASURE;
                            cnt   <= MEAS_W'(1);
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    ST_HOLDOFF: if (cnt == HOLD_LAST) begin
                        idx <= idx_next;
                        cnt <= '0;
                        if (enable) begin
                            state <= ST_TRIG;
                            trig  <= sel_next;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Bench for sonar_scan_ctrl: vector table, randomized scans against a width
// model, plus abort and asynchronous-reset sequences.
module tb_sonar_scan_ctrl;
    localparam int N       = 4;
    localparam int TRIG    = 10;
    localparam int TIMEOUT = 500;
    localparam int HOLD    = 50;
    localparam int NEAR    = 20;
    localparam int FAR     = 200;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [N-1:0] echo;
    logic [N-1:0] trig, detected;
    logic         run, meas_valid, meas_timeout;
    logic [2:0]   meas_idx;
    logic [23:0]  meas_cycles;

    int n_chk = 0, n_pass = 0;
    int cyc = 0, ref_cyc = 0;
    int m_idx = 0;
    logic [N-1:0] mdet = '0;

    typedef struct { int w; int pre; bit to; int c; bit det; } vec_t;
    vec_t tbl[12];

    sonar_scan_ctrl #(.N_SENSORS(N), .TRIG_CYC(TRIG), .TIMEOUT_CYC(TIMEOUT),
                      .HOLDOFF_CYC(HOLD), .NEAR_CYC(NEAR), .FAR_CYC(FAR)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .echo(echo), .trig(trig),
        .detected(detected), .run(run), .meas_valid(meas_valid), .meas_idx(meas_idx),
        .meas_cycles(meas_cycles), .meas_timeout(meas_timeout));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp, input int tol);
        int d;
        n_chk++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_trig"}, int'(trig), 0, 0);
        chk({tag, "_detected"}, int'(detected), 0, 0);
        chk({tag, "_run"}, int'(run), 0, 0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0, 0);
        chk({tag, "_meas_idx"}, int'(meas_idx), 0, 0);
        chk({tag, "_meas_cycles"}, int'(meas_cycles), 0, 0);
        chk({tag, "_meas_timeout"}, int'(meas_timeout), 0, 0);
    endtask

    // Expected result of one measurement from the raw echo width (0 = no echo)
    function automatic void ref_meas(input int w, output bit to, output int c, output bit det);
        to  = (w == 0) || (w > TIMEOUT);
        c   = to ? TIMEOUT : w;
        det = !to && (w > NEAR) && (w < FAR);
    endfunction

    task automatic drive_pulse(input logic [1:0] i, input int pre, input int w);
        if (pre > 0) begin
            repeat (pre) @(negedge clk);
            echo[i] = 1'b0;
            repeat (5) @(negedge clk);
        end else begin
            repeat (3) @(negedge clk);
        end
        if (w > 0) begin
            echo[i] = 1'b1;
            repeat (w) @(negedge clk);
            echo[i] = 1'b0;
        end
    endtask

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (trig != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("trig_start_seen", 0, 1, 0);
    endtask

    task automatic wait_trig_low();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (trig == '0) break;
        end
    endtask

    // One full scan of sensor m_idx: trigger checks, echo drive, result checks
    task automatic scan(input int w, input int pre, input int gap, input bit noise,
                        input bit e_to, input int e_c, input bit e_det);
        int i, hi, nj, nw;
        bit ok;
        i = m_idx;
        wait_trig(ok);
        if (!ok) return;
        if (gap >= 0) chk("trig_gap", cyc - ref_cyc, gap, 0);
        chk("trig_sel", int'(trig), 1 << i, 0);
        if (pre > 0) echo[i] = 1'b1;
        hi = 1;
        while (hi < 100) begin
            @(negedge clk);
            if (trig == '0) break;
            hi++;
        end
        chk("trig_width", hi, TRIG, 0);
        fork
            drive_pulse(2'(i), pre, w);
        join_none
        if (noise) begin
            nj = (i + 1 + int'($urandom_range(0, N - 2))) % N;
            nw = int'($urandom_range(1, 8));
            fork
                drive_pulse(2'(nj), 0, nw);
            join_none
        end
        ok = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            if (meas_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("meas_valid_seen", int'(ok), 1, 0);
        if (!ok) return;
        ref_cyc = cyc;
        mdet[i] = e_det;
        m_idx   = (m_idx + 1) % N;
        chk("meas_idx", int'(meas_idx), i, 0);
        chk("meas_timeout", int'(meas_timeout), int'(e_to), 0);
        chk("meas_cycles", int'(meas_cycles), e_c, e_to ? 0 : 1);
        chk("detected", int'(detected), int'(mdet), 0);
        chk("run", int'(run), int'(|mdet), 0);
        @(negedge clk);
        chk("meas_valid_pulse", int'(meas_valid), 0, 0);
    endtask

    initial begin
        bit ok, to, det, mv_seen;
        int w, c, mode;
        logic [N-1:0] trig_or;

        tbl[0]  = '{100, 0, 1'b0, 100, 1'b1};
        tbl[1]  = '{20,  0, 1'b0, 20,  1'b0};
        tbl[2]  = '{150, 0, 1'b0, 150, 1'b1};
        tbl[3]  = '{50,  0, 1'b0, 50,  1'b1};
        tbl[4]  = '{150, 0, 1'b0, 150, 1'b1};
        tbl[5]  = '{200, 0, 1'b0, 200, 1'b0};
        tbl[6]  = '{0,   0, 1'b1, 500, 1'b0};
        tbl[7]  = '{19,  0, 1'b0, 19,  1'b0};
        tbl[8]  = '{199, 0, 1'b0, 199, 1'b1};
        tbl[9]  = '{21,  0, 1'b0, 21,  1'b1};
        tbl[10] = '{600, 0, 1'b1, 500, 1'b0};
        tbl[11] = '{100, 0, 1'b0, 100, 1'b1};

        rst_n  = 1'b0;
        enable = 1'b1;
        echo   = '0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n   = 1'b1;
        ref_cyc = cyc;

        for (int t = 0; t < 12; t++)
            scan(tbl[t].w, tbl[t].pre, (t == 0) ? 1 : HOLD, 1'b0,
                 tbl[t].to, tbl[t].c, tbl[t].det);

        // Echo already high when the trigger ends must not count as a rising edge
        scan(60, 30, HOLD, 1'b0, 1'b0, 60, 1'b1);

        for (int r = 0; r < 40 && (r < 20 || m_idx != 3); r++) begin
            mode = int'($urandom_range(0, 9));
            if (mode == 0)      w = 0;
            else if (mode == 1) w = int'($urandom_range(520, 560));
            else                w = int'($urandom_range(1, 260));
            ref_meas(w, to, c, det);
            scan(w, 0, HOLD, 1'b1, to, c, det);
        end

        // Abort mid-measurement on sensor 3, then resume on the same sensor
        wait_trig(ok);
        chk("abort_trig_sel", int'(trig), 1 << m_idx, 0);
        wait_trig_low();
        repeat (2) @(negedge clk);
        echo[m_idx] = 1'b1;
        repeat (30) @(negedge clk);
        enable  = 1'b0;
        mv_seen = 1'b0;
        trig_or = '0;
        repeat (20) begin
            @(negedge clk);
            mv_seen |= meas_valid;
            trig_or |= trig;
        end
        chk("abort_no_valid", int'(mv_seen), 0, 0);
        chk("abort_trig_low", int'(trig_or), 0, 0);
        chk("abort_det_kept", int'(detected), int'(mdet), 0);
        echo = '0;
        repeat (5) @(negedge clk);
        enable  = 1'b1;
        ref_cyc = cyc;
        scan(80, 0, 1, 1'b0, 1'b0, 80, 1'b1);

        // Asynchronous reset in the middle of a measurement
        wait_trig(ok);
        wait_trig_low();
        repeat (2) @(negedge clk);
        echo[m_idx] = 1'b1;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("areset");
        echo   = '0;
        enable = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        trig_or = '0;
        repeat (20) begin
            @(negedge clk);
            trig_or |= trig;
        end
        chk("idle_after_reset_trig", int'(trig_or), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
